mem_port_arbiter: RTL and testbench

Shares one multi-cycle unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined CPU. Each port makes a held-request / one-cycle-ready handshake. The arbiter latches the granted request, drives the memory-side valid/ready handshake, and returns read data. The pipeline derives its IF and MEM stalls from `req & ~ready`. Data-port requests normally win; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch (IF) and load/store (DM).
// Data requests win by default; a streak counter bounds how long a waiting fetch can be starved.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state, state_n;
    logic                owner_dm, owner_dm_n;
    logic [STREAK_W-1:0] streak, streak_n;
    logic                mem_valid_n, mem_we_n, if_ready_n, dm_ready_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n, if_rdata_n, dm_rdata_n;
    logic                streak_full, grant_dm, grant_if;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            streak    <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_n;
            owner_dm  <= owner_dm_n;
            streak    <= streak_n;
            mem_valid <= mem_valid_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_ready  <= if_ready_n;
            dm_ready  <= dm_ready_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
        end
    end

    // Priority: DM wins unless it has already won MAX_DM_STREAK times while IF waited
    always_comb begin
        streak_full = (streak == STREAK_W'(MAX_DM_STREAK));
        grant_dm    = dm_req && (!if_req || !streak_full);
        grant_if    = if_req && !grant_dm;
    end

    // Next-state and output logic
    always_comb begin
        state_n     = state;
        owner_dm_n  = owner_dm;
        streak_n    = streak;
        mem_valid_n = mem_valid;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_ready_n  = 1'b0;
        dm_ready_n  = 1'b0;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;

        case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_n     = BUSY;
                    owner_dm_n  = 1'b1;
                    mem_valid_n = 1'b1;
                    mem_we_n    = dm_we;
                    mem_addr_n  = dm_addr;
                    mem_wdata_n = dm_wdata;
                    if (if_req) begin
                        streak_n = streak_full ? streak : streak + STREAK_W'(1);
                    end else begin
                        streak_n = '0;
                    end
                end else if (grant_if) begin
                    state_n     = BUSY;
                    owner_dm_n  = 1'b0;
                    mem_valid_n = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = if_addr;
                    streak_n    = '0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_n     = DONE;
                    mem_valid_n = 1'b0;
                    if (owner_dm) begin
                        dm_ready_n = 1'b1;
                        if (!mem_we) begin
                            dm_rdata_n = mem_rdata;
                        end
                    end else begin
                        if_ready_n = 1'b1;
                        if_rdata_n = mem_rdata;
                    end
                end
            end
            // One-cycle gap so the finishing requester's still-high req is not re-granted
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, instantiated with MAX_DM_STREAK = 2.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DM_STREAK(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ready(if_ready),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_ready(dm_ready),
        .dm_rdata(dm_rdata),
        .mem_valid(mem_valid),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge: drive and sample point
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".mem_valid"}, 64'(mem_valid), 64'd0);
        check({tag, ".if_ready"},  64'(if_ready),  64'd0);
        check({tag, ".dm_ready"},  64'(dm_ready),  64'd0);
    endtask

    logic exp_dm [6];
    logic [1:0] exp_streak [6];

    initial begin
        exp_dm     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_streak = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

        reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        tick(); tick();
        check_idle_outputs("reset");
        check("reset.mem_addr", 64'(mem_addr), 64'd0);
        check("reset.if_rdata", 64'(if_rdata), 64'd0);
        check("reset.state", 64'(dut.state), 64'd0);
        reset = 1'b1;
        tick();

        // Single fetch, latency 3
        if_req = 1'b1; if_addr = 32'h40;
        tick(); // cycle 1
        check("f1.c1.mem_valid", 64'(mem_valid), 64'd1);
        check("f1.c1.mem_addr", 64'(mem_addr), 64'h40);
        check("f1.c1.mem_we", 64'(mem_we), 64'd0);
        tick(); // cycle 2
        check("f1.c2.mem_valid", 64'(mem_valid), 64'd1);
        check("f1.c2.if_ready", 64'(if_ready), 64'd0);
        tick(); // cycle 3
        check("f1.c3.mem_valid", 64'(mem_valid), 64'd1);
        mem_ready = 1'b1; mem_rdata = 32'h00A00093;
        tick(); // cycle 4
        mem_ready = 1'b0;
        check("f1.c4.if_ready", 64'(if_ready), 64'd1);
        check("f1.c4.if_rdata", 64'(if_rdata), 64'h00A00093);
        check("f1.c4.dm_ready", 64'(dm_ready), 64'd0);
        check("f1.c4.mem_valid", 64'(mem_valid), 64'd0);
        if_req = 1'b0;
        tick(); // cycle 5
        check_idle_outputs("f1.c5");
        check("f1.c5.state", 64'(dut.state), 64'd0);

        // Simultaneous requests: DM first, then IF
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        tick();
        check("sim.dm.mem_addr", 64'(mem_addr), 64'h100);
        check("sim.dm.mem_we", 64'(mem_we), 64'd0);
        check("sim.dm.streak", 64'(dut.streak), 64'd1);
        mem_ready = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_ready = 1'b0;
        check("sim.dm.dm_ready", 64'(dm_ready), 64'd1);
        check("sim.dm.if_ready", 64'(if_ready), 64'd0);
        check("sim.dm.dm_rdata", 64'(dm_rdata), 64'h55);
        dm_req = 1'b0;
        tick();
        check_idle_outputs("sim.gap");
        tick();
        check("sim.if.mem_addr", 64'(mem_addr), 64'h44);
        check("sim.if.streak", 64'(dut.streak), 64'd0);
        mem_ready = 1'b1; mem_rdata = 32'h13;
        tick();
        mem_ready = 1'b0;
        check("sim.if.if_ready", 64'(if_ready), 64'd1);
        check("sim.if.dm_ready", 64'(dm_ready), 64'd0);
        check("sim.if.if_rdata", 64'(if_rdata), 64'h13);
        if_req = 1'b0;
        tick();

        // Starvation with MAX_DM_STREAK = 2: DM, DM, IF, DM, DM, IF
        if_req = 1'b1; if_addr = 32'h48;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
        for (int i = 0; i < 6; i++) begin
            tick(); // BUSY
            check($sformatf("starve%0d.mem_addr", i), 64'(mem_addr),
                  exp_dm[i] ? 64'h104 : 64'h48);
            check($sformatf("starve%0d.streak", i), 64'(dut.streak), 64'(exp_streak[i]));
            mem_ready = 1'b1;
            mem_rdata = exp_dm[i] ? 32'h55 : 32'h1000 + 32'(i);
            tick(); // DONE
            mem_ready = 1'b0;
            check($sformatf("starve%0d.dm_ready", i), 64'(dm_ready), 64'(exp_dm[i]));
            check($sformatf("starve%0d.if_ready", i), 64'(if_ready), 64'(!exp_dm[i]));
            if (i == 5) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            tick(); // IDLE
        end
        check("starve.if_rdata", 64'(if_rdata), 64'h1005);
        check("starve.dm_rdata", 64'(dm_rdata), 64'h55);

        // Store: payload stable, dm_rdata untouched
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        tick();
        dm_wdata = 32'h0; dm_addr = 32'h0;
        check("st.mem_we", 64'(mem_we), 64'd1);
        check("st.mem_addr", 64'(mem_addr), 64'h200);
        check("st.mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        tick();
        check("st.hold.mem_valid", 64'(mem_valid), 64'd1);
        check("st.hold.mem_addr", 64'(mem_addr), 64'h200);
        check("st.hold.mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        check("st.dm_ready", 64'(dm_ready), 64'd1);
        check("st.dm_rdata", 64'(dm_rdata), 64'h55);
        dm_req = 1'b0; dm_we = 1'b0;
        tick();

        // Reset in cycle 2 of a long fetch
        if_req = 1'b1; if_addr = 32'h80;
        tick(); // cycle 1
        check("rst.c1.mem_valid", 64'(mem_valid), 64'd1);
        tick(); // cycle 2
        reset = 1'b0; if_req = 1'b0;
        tick();
        reset = 1'b1;
        check_idle_outputs("rst.after");
        check("rst.mem_we", 64'(mem_we), 64'd0);
        check("rst.mem_addr", 64'(mem_addr), 64'd0);
        check("rst.mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst.if_rdata", 64'(if_rdata), 64'd0);
        check("rst.dm_rdata", 64'(dm_rdata), 64'd0);
        check("rst.state", 64'(dut.state), 64'd0);
        check("rst.streak", 64'(dut.streak), 64'd0);
        mem_ready = 1'b1; mem_rdata = 32'hBAD0;
        tick();
        mem_ready = 1'b0;
        check_idle_outputs("rst.late");
        check("rst.late.if_rdata", 64'(if_rdata), 64'd0);
        if_req = 1'b1; if_addr = 32'h84;
        tick();
        check("rst.new.mem_valid", 64'(mem_valid), 64'd1);
        check("rst.new.mem_addr", 64'(mem_addr), 64'h84);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE;
        tick();
        mem_ready = 1'b0;
        check("rst.new.if_ready", 64'(if_ready), 64'd1);
        check("rst.new.if_rdata", 64'(if_rdata), 64'hCAFE);
        if_req = 1'b0;
        tick();

        // Spurious mem_ready while idle
        mem_ready = 1'b1; mem_rdata = 32'hBAD1;
        tick();
        check_idle_outputs("spur1");
        tick();
        mem_ready = 1'b0;
        check_idle_outputs("spur2");
        check("spur.if_rdata", 64'(if_rdata), 64'hCAFE);
        check("spur.dm_rdata", 64'(dm_rdata), 64'd0);
        check("spur.state", 64'(dut.state), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Ready pulses must never coincide
    always @(negedge clk) begin
        if (reset && if_ready && dm_ready) begin
            n_cmp++;
            n_err++;
            $error("FAIL both_ready: observed if_ready=1 dm_ready=1 expected at most one");
        end
    end

endmodule
